// File: rtl/axi_rd_path_switch.sv
// ============================================================================
// axi_rd_path_switch
// ----------------------------------------------------------------------------
// Steers the AXI read channels of a CNN engine either straight to the XHB
// fabric (mode 0, DIRECT) or through the AIDC decompressor (mode 1, COMP).
// A path change is only committed once every outstanding read has returned its
// last beat and the R holding register is empty, so a burst can never be split
// across two paths.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   enable_i          requested path (1 = AIDC, 0 = XHB)
//   mode_o            path currently in effect
//   err_o             sticky flag: the unselected path drove R valid
//   s_ar_*            AR slave side (from CNN engine)
//   e_ar_* / m_ar_*   AR master sides (to AIDC / to XHB)
//   e_r_*  / m_r_*    R slave sides (from AIDC / from XHB)
//   s_r_*             R master side (to CNN engine)
//
// Payload layouts
//   AR : {id[ID_W], addr[ADDR_W]}
//   R  : {id[ID_W], resp[2], last[1], data[DATA_W]}   (last is bit DATA_W)
//
// Handshake rule used on every channel: a transfer happens in a cycle where
// valid and ready are both 1 at the rising clock edge. valid never depends on
// the same channel's ready; once s_r_valid is raised it stays up, with the
// payload frozen, until s_r_ready accepts it.
// ============================================================================
module axi_rd_path_switch #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4,
    parameter int DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       enable_i,
    output logic                       mode_o,
    output logic                       err_o,

    input  logic                       s_ar_valid,
    output logic                       s_ar_ready,
    input  logic [ID_W+ADDR_W-1:0]     s_ar_pld,

    output logic                       e_ar_valid,
    input  logic                       e_ar_ready,
    output logic [ID_W+ADDR_W-1:0]     e_ar_pld,

    output logic                       m_ar_valid,
    input  logic                       m_ar_ready,
    output logic [ID_W+ADDR_W-1:0]     m_ar_pld,

    input  logic                       e_r_valid,
    output logic                       e_r_ready,
    input  logic [ID_W+3+DATA_W-1:0]   e_r_pld,

    input  logic                       m_r_valid,
    output logic                       m_r_ready,
    input  logic [ID_W+3+DATA_W-1:0]   m_r_pld,

    output logic                       s_r_valid,
    input  logic                       s_r_ready,
    output logic [ID_W+3+DATA_W-1:0]   s_r_pld
);

    localparam int R_W = ID_W + 3 + DATA_W;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_DIRECT = 2'd0,
        ST_COMP   = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic             mode;
    logic             mode_nxt;
    logic [3:0]       outs;      // reads accepted on AR whose last beat is not yet delivered
    logic             err;

    logic             rbuf_valid;
    logic [R_W-1:0]   rbuf_pld;

    // ------------------------------------------------------------------------
    // AR path (purely combinational)
    // ------------------------------------------------------------------------
    // ar_open gates both ready upstream and valid downstream; gating valid too
    // keeps a downstream port from taking a request the engine never saw
    // accepted (e.g. while draining, or with the counter saturated).
    logic ar_open;
    logic sel_ar_ready;
    logic ar_hs;

    assign ar_open      = (state != ST_DRAIN) && (outs != 4'd15);
    assign sel_ar_ready = mode ? e_ar_ready : m_ar_ready;

    assign s_ar_ready   = sel_ar_ready && ar_open;
    assign e_ar_valid   = s_ar_valid && ar_open &&  mode;
    assign m_ar_valid   = s_ar_valid && ar_open && !mode;
    assign e_ar_pld     = s_ar_pld;
    assign m_ar_pld     = s_ar_pld;

    assign ar_hs        = s_ar_valid && s_ar_ready;

    // ------------------------------------------------------------------------
    // R path: one-entry holding register fed from the selected source
    // ------------------------------------------------------------------------
    logic             sel_r_valid;
    logic [R_W-1:0]   sel_r_pld;
    logic             sel_r_ready;
    logic             unsel_r_valid;
    logic             r_load;
    logic             r_last_hs;

    assign sel_r_valid   = mode ? e_r_valid : m_r_valid;
    assign sel_r_pld     = mode ? e_r_pld   : m_r_pld;
    assign unsel_r_valid = mode ? m_r_valid : e_r_valid;

    // Accept a new beat when the register is empty or is being emptied this
    // cycle, so back-to-back beats flow at one per clock.
    assign sel_r_ready   = !rbuf_valid || s_r_ready;
    assign e_r_ready     =  mode && sel_r_ready;
    assign m_r_ready     = !mode && sel_r_ready;

    assign r_load        = sel_r_valid && sel_r_ready;

    assign s_r_valid     = rbuf_valid;
    assign s_r_pld       = rbuf_pld;

    assign r_last_hs     = rbuf_valid && s_r_ready && rbuf_pld[DATA_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rbuf_valid <= 1'b0;
            rbuf_pld   <= '0;
        end else begin
            if (r_load) begin
                rbuf_valid <= 1'b1;
                rbuf_pld   <= sel_r_pld;
            end else if (s_r_ready) begin
                rbuf_valid <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outstanding-read counter
    // ------------------------------------------------------------------------
    // Saturation is avoided upstream (AR closes at 15) and a last beat can
    // only arrive for a read that was counted, so no explicit clamps here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            outs <= 4'd0;
        end else begin
            case ({ar_hs, r_last_hs})
                2'b10:   outs <= outs + 4'd1;
                2'b01:   outs <= outs - 4'd1;
                default: outs <= outs;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sticky protocol error: a beat offered by the path we are not listening to
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else begin
            err <= err || unsel_r_valid;
        end
    end

    assign err_o = err;

    // ------------------------------------------------------------------------
    // Mode FSM
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_DIRECT;
            mode  <= 1'b0;
        end else begin
            state <= state_nxt;
            mode  <= mode_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mode_nxt  = mode;
        case (state)
            ST_DIRECT, ST_COMP: begin
                if (enable_i != mode) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // A request withdrawn before the drain completes cancels the
                // switch; this takes priority over completing it.
                if (enable_i == mode) begin
                    state_nxt = mode ? ST_COMP : ST_DIRECT;
                end else if ((outs == 4'd0) && !rbuf_valid) begin
                    mode_nxt  = ~mode;
                    state_nxt = mode ? ST_DIRECT : ST_COMP;
                end
            end
            default: begin
                state_nxt = ST_DIRECT;
                mode_nxt  = 1'b0;
            end
        endcase
    end

    assign mode_o = mode;

endmodule

// File: doc/axi_rd_path_switch.md
AXI_RD_PATH_SWITCH -- requirements
Module: axi_rd_path_switch

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, AR address width.
REQ-002 SHALL have parameter ID_W, default 4, AXI ID width.
REQ-003 SHALL have parameter DATA_W, default 32, R data width.
REQ-004 SHALL have one clock and an asynchronous active-low reset; every port below is synchronous to clk.
- AR payload (AR_W) = {id[ID_W], addr[ADDR_W]}.
- R payload (R_W) = {id[ID_W], resp[2], last[1], data[DATA_W]}; last is bit DATA_W.
REQ-005 SHALL have the following ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- enable_i  in  1  requested path: 1 = AIDC (compressed), 0 = direct to XHB
- mode_o  out  1  path currently in effect
- err_o  out  1  sticky: unselected path drove R valid
- s_ar_valid  in  1  AR valid from CNN engine
- s_ar_ready  out  1  AR ready to CNN engine
- s_ar_pld  in  AR_W  AR payload from CNN engine
- e_ar_valid  out  1  AR valid to AIDC
- e_ar_ready  in  1  AR ready from AIDC
- e_ar_pld  out  AR_W  AR payload to AIDC
- m_ar_valid  out  1  AR valid to XHB
- m_ar_ready  in  1  AR ready from XHB
- m_ar_pld  out  AR_W  AR payload to XHB
- e_r_valid  in  1  R valid from AIDC
- e_r_ready  out  1  R ready to AIDC
- e_r_pld  in  R_W  R payload from AIDC
- m_r_valid  in  1  R valid from XHB
- m_r_ready  out  1  R ready to XHB
- m_r_pld  in  R_W  R payload from XHB
- s_r_valid  out  1  R valid to CNN engine
- s_r_ready  in  1  R ready from CNN engine
- s_r_pld  out  R_W  R payload to CNN engine

Function
REQ-006 SHALL implement the FSM DIRECT (mode 0), COMP (mode 1) and DRAIN; mode_o SHALL equal the mode register.
REQ-007 SHALL leave DIRECT or COMP for DRAIN the cycle after enable_i != mode_o is sampled.
REQ-008 In DRAIN, if enable_i == mode_o, the FSM SHALL return to its prior state next cycle without changing mode.
REQ-009 In DRAIN with outs == 0 and the R buffer empty, the FSM SHALL flip mode and enter the target state next cycle.
REQ-010 The AR path SHALL be combinational: payload to both outputs; valid only to the mode-selected path.
REQ-011 s_ar_ready SHALL = selected ready AND state != DRAIN AND outs < 15.
REQ-012 outs (4-bit) SHALL increment on an s_ar handshake and decrement on an s_r handshake with last=1; both together leave it unchanged.
REQ-013 outs SHALL not wrap: AR is stalled at 15, and a decrement at 0 does not occur by construction.
REQ-014 R SHALL pass through a 1-entry register from the mode-selected source, giving 1-cycle latency.
REQ-015 Selected r_ready SHALL = buffer empty OR s_r_ready, giving full throughput.
REQ-016 Unselected r_ready SHALL be 0.
REQ-017 err_o SHALL set when the unselected r_valid is 1, and SHALL clear only on reset.
REQ-018 s_r_pld SHALL hold stable while s_r_valid=1 and s_r_ready=0.

Reset
REQ-019 On rst_n=0 the block SHALL immediately clear to: state DIRECT, mode_o 0, outs 0, R buffer empty, err_o 0, s_r_valid 0, s_r_pld 0.
REQ-020 Reset mid-transaction SHALL discard in-flight beats and count, with no recovery.

Verification
REQ-021 Bench SHALL cover: enable_i=0; 3 ARs with m_ar_ready=1 -> m_ar_valid pulses 3, e_ar_valid 0, outs=3.
REQ-022 Bench SHALL cover: outs=2, enable_i 0->1 -> DRAIN with s_ar_ready 0; two last beats returned -> mode_o=1 two cycles after the final s_r handshake.
REQ-023 Bench SHALL cover: 15 ARs with no R -> s_ar_ready 0 at outs=15; one last beat -> s_ar_ready 1.
REQ-024 Bench SHALL cover: m_r_valid held with data 0xA5A5_0001 and s_r_ready toggling -> s_r_pld stable while stalled, no beat lost or duplicated.
REQ-025 Bench SHALL cover: mode 0 with e_r_valid=1 -> err_o=1 sticky and e_r_ready 0; enable_i pulse 1 for 1 cycle during DRAIN -> return to DIRECT with mode_o 0.
REQ-026 Bench SHALL cover: rst_n low during DRAIN with outs=4 -> outs 0, mode_o 0, s_r_valid 0 the same cycle.
